// File: rtl/param_digital_lock.sv
// param_digital_lock: parametrised keypad lock controller with set-and-confirm
// code entry, edge-qualified keys, idle timeout and entry-progress output.
// Optional lockout after repeated failures: define PARAM_LOCK_LOCKOUT_EN.
module param_digital_lock #(
  parameter int unsigned CLOCK_FREQ      = 50000000,
  parameter int unsigned TIMEOUT_CYCLES  = 10 * CLOCK_FREQ,
  parameter int unsigned PASSCODE_LENGTH = 4,
  parameter int unsigned KEY_WIDTH       = 4,
  parameter logic [KEY_WIDTH*PASSCODE_LENGTH-1:0] DEFAULT_PASSCODE = 16'h8148,
  parameter int unsigned MAX_ATTEMPTS    = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 30 * CLOCK_FREQ
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [KEY_WIDTH-1:0]                 key,
  output logic                                 locked,
  output logic                                 error,
  output logic                                 lockout,
  output logic [$clog2(PASSCODE_LENGTH+1)-1:0] entry_count
);

  localparam int unsigned CODE_W = KEY_WIDTH * PASSCODE_LENGTH;
  localparam int unsigned CNT_W  = $clog2(PASSCODE_LENGTH + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PARAM_LOCK_LOCKOUT_EN
  localparam int unsigned FAIL_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned LO_W   = $clog2(LOCKOUT_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    ST_SET1,
    ST_SET2,
    ST_SET_CHECK,
    ST_LOCK_READ,
    ST_LOCK_CHECK
`ifdef PARAM_LOCK_LOCKOUT_EN
    , ST_LOCKOUT
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  entry_q, entry_d;
  logic [CODE_W-1:0]  cand_q, cand_d;
  logic [CODE_W-1:0]  saved_q, saved_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TO_W-1:0]    idle_q, idle_d;
  logic               key_held_q, key_held_d;
  logic               locked_q, locked_d;
  logic               error_q, error_d;
`ifdef PARAM_LOCK_LOCKOUT_EN
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic [LO_W-1:0]    lo_cnt_q, lo_cnt_d;
  logic               lockout_q, lockout_d;
`endif

  logic               key_edge;
  logic               last_digit;
  logic               collecting;
  logic               timer_run;
  logic               expired;
  logic [CODE_W-1:0]  shifted;

  // Qualifiers shared by the next-state logic
  assign key_edge   = (|key) && !key_held_q;
  assign last_digit = key_edge && (count_q == CNT_W'(PASSCODE_LENGTH - 1));
  assign shifted    = (entry_q << KEY_WIDTH) | CODE_W'(key);
  assign collecting = (state_q == ST_SET1) || (state_q == ST_SET2) ||
                      (state_q == ST_LOCK_READ);
  assign timer_run  = (count_q != '0) || (state_q == ST_SET2);
  assign expired    = timer_run && (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output computation
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    cand_d     = cand_q;
    saved_d    = saved_q;
    count_d    = count_q;
    idle_d     = '0;
    key_held_d = |key;
    locked_d   = locked_q;
    error_d    = error_q;
`ifdef PARAM_LOCK_LOCKOUT_EN
    fail_d     = fail_q;
    lo_cnt_d   = lo_cnt_q;
    lockout_d  = lockout_q;
`endif

    // Digit capture and idle timeout; a key edge on the expiry cycle wins
    if (collecting) begin
      if (key_edge) begin
        entry_d = shifted;
        count_d = count_q + CNT_W'(1);
        error_d = 1'b0;
      end else if (expired) begin
        error_d = 1'b1;
        entry_d = '0;
        count_d = '0;
        state_d = (state_q == ST_LOCK_READ) ? ST_LOCK_READ : ST_SET1;
      end else if (timer_run) begin
        idle_d = idle_q + TO_W'(1);
      end
    end

    case (state_q)
      ST_SET1: begin
        if (last_digit) begin
          cand_d  = shifted;
          entry_d = '0;
          count_d = '0;
          state_d = ST_SET2;
        end
      end
      ST_SET2: begin
        if (last_digit) state_d = ST_SET_CHECK;
      end
      ST_SET_CHECK: begin
        entry_d = '0;
        count_d = '0;
        if (entry_q == cand_q) begin
          saved_d  = cand_q;
          locked_d = 1'b1;
          state_d  = ST_LOCK_READ;
        end else begin
          error_d = 1'b1;
          state_d = ST_SET1;
        end
      end
      ST_LOCK_READ: begin
        if (last_digit) state_d = ST_LOCK_CHECK;
      end
      ST_LOCK_CHECK: begin
        entry_d = '0;
        count_d = '0;
        if (entry_q == saved_q) begin
          locked_d = 1'b0;
`ifdef PARAM_LOCK_LOCKOUT_EN
          fail_d   = '0;
`endif
          state_d  = ST_SET1;
        end else begin
          error_d = 1'b1;
          state_d = ST_LOCK_READ;
`ifdef PARAM_LOCK_LOCKOUT_EN
          fail_d  = fail_q + FAIL_W'(1);
          if (fail_q == FAIL_W'(MAX_ATTEMPTS - 1)) begin
            lockout_d = 1'b1;
            lo_cnt_d  = '0;
            state_d   = ST_LOCKOUT;
          end
`endif
        end
      end
`ifdef PARAM_LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (lo_cnt_q == LO_W'(LOCKOUT_CYCLES - 1)) begin
          lo_cnt_d  = '0;
          lockout_d = 1'b0;
          fail_d    = '0;
          state_d   = ST_LOCK_READ;
        end else begin
          lo_cnt_d = lo_cnt_q + LO_W'(1);
        end
      end
`endif
      default: state_d = ST_SET1;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SET1;
      entry_q    <= '0;
      cand_q     <= '0;
      saved_q    <= DEFAULT_PASSCODE;
      count_q    <= '0;
      idle_q     <= '0;
      key_held_q <= 1'b1;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
`ifdef PARAM_LOCK_LOCKOUT_EN
      fail_q     <= '0;
      lo_cnt_q   <= '0;
      lockout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      cand_q     <= cand_d;
      saved_q    <= saved_d;
      count_q    <= count_d;
      idle_q     <= idle_d;
      key_held_q <= key_held_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
`ifdef PARAM_LOCK_LOCKOUT_EN
      fail_q     <= fail_d;
      lo_cnt_q   <= lo_cnt_d;
      lockout_q  <= lockout_d;
`endif
    end
  end

  assign locked      = locked_q;
  assign error       = error_q;
  assign entry_count = count_q;
`ifdef PARAM_LOCK_LOCKOUT_EN
  assign lockout     = lockout_q;
`else
  // Lockout parameters have no effect here; any legal setting (>= 1) gives 0
  localparam bit LOCKOUT_CFG_OK = (MAX_ATTEMPTS >= 1) && (LOCKOUT_CYCLES >= 1);
  assign lockout     = 1'b0 & LOCKOUT_CFG_OK;
`endif

endmodule

// File: tb/tb_param_digital_lock.sv
// Directed bench for param_digital_lock (TIMEOUT=100, LOCKOUT=200, 3 attempts).
module tb_param_digital_lock;

  localparam int unsigned T = 100;
  localparam int unsigned L = 200;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key;
  logic       locked;
  logic       err;
  logic       lockout;
  logic [2:0] entry_count;

  int tests  = 0;
  int failed = 0;

  param_digital_lock #(
    .CLOCK_FREQ      (1000),
    .TIMEOUT_CYCLES  (T),
    .PASSCODE_LENGTH (4),
    .KEY_WIDTH       (4),
    .DEFAULT_PASSCODE(16'h8148),
    .MAX_ATTEMPTS    (3),
    .LOCKOUT_CYCLES  (L)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key        (key),
    .locked     (locked),
    .error      (err),
    .lockout    (lockout),
    .entry_count(entry_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic lk, input logic er,
                            input logic lo, input logic [2:0] cnt);
    check({tag, ".locked"}, 32'(locked), 32'(lk));
    check({tag, ".error"}, 32'(err), 32'(er));
    check({tag, ".lockout"}, 32'(lockout), 32'(lo));
    check({tag, ".entry_count"}, 32'(entry_count), 32'(cnt));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key = d;
    tick();
    key = 4'h0;
    tick();
  endtask

  task automatic enter(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
  endtask

  initial begin
    // Reset with a key held through release
    reset = 1'b1;
    key   = 4'h3;
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("held_through_reset", 32'(entry_count), 32'd0);
    key = 4'h0;
    tick();
    press(4'h5);
    check("first_press", 32'(entry_count), 32'd1);
    press(4'h6);
    check("second_press", 32'(entry_count), 32'd2);
    #1 reset = 1'b1;
    #1;
    check_outs("async_reset", 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    reset = 1'b0;
    tick();

    // Set code 1234 and confirm; locked two cycles after the final edge
    press(4'h1);
    press(4'h2);
    check("set1_progress", 32'(entry_count), 32'd2);
    press(4'h3);
    press(4'h4);
    check_outs("set1_done", 1'b0, 1'b0, 1'b0, 3'd0);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    key = 4'h4;
    tick();
    check("set_check_cycle.locked", 32'(locked), 32'd0);
    check("set_check_cycle.count", 32'(entry_count), 32'd4);
    key = 4'h0;
    tick();
    check_outs("locked_1234", 1'b1, 1'b0, 1'b0, 3'd0);

    // Unlock with 1234, then a mismatched new-code pair
    press(4'h1);
    press(4'h2);
    press(4'h3);
    key = 4'h4;
    tick();
    check("lock_check_cycle.locked", 32'(locked), 32'd1);
    key = 4'h0;
    tick();
    check_outs("unlocked", 1'b0, 1'b0, 1'b0, 3'd0);
    enter(16'h5678);
    check_outs("set1_5678", 1'b0, 1'b0, 1'b0, 3'd0);
    enter(16'h5679);
    check_outs("set_mismatch", 1'b0, 1'b1, 1'b0, 3'd0);
    enter(16'h1234);
    enter(16'h1234);
    check_outs("relock", 1'b1, 1'b0, 1'b0, 3'd0);

    // Repeated wrong codes
    enter(16'h9999);
    check_outs("fail1", 1'b1, 1'b1, 1'b0, 3'd0);
    enter(16'h9999);
    check_outs("fail2", 1'b1, 1'b1, 1'b0, 3'd0);
`ifdef PARAM_LOCK_LOCKOUT_EN
    press(4'h9);
    press(4'h9);
    press(4'h9);
    key = 4'h9;
    tick();
    check("pre_lockout", 32'(lockout), 32'd0);
    key = 4'h0;
    tick();
    check_outs("lockout_start", 1'b1, 1'b1, 1'b1, 3'd0);
    for (int i = 1; i < int'(L); i++) begin
      key = (i % 4 == 1) ? 4'h5 : 4'h0;
      tick();
    end
    check_outs("lockout_end", 1'b1, 1'b1, 1'b1, 3'd0);
    tick();
    check_outs("lockout_release", 1'b1, 1'b1, 1'b0, 3'd0);
    enter(16'h1234);
    check_outs("unlock_after_lockout", 1'b0, 1'b0, 1'b0, 3'd0);
`else
    enter(16'h9999);
    check_outs("fail3_no_lockout", 1'b1, 1'b1, 1'b0, 3'd0);
    enter(16'h1234);
    check_outs("fourth_attempt_unlocks", 1'b0, 1'b0, 1'b0, 3'd0);
`endif

    // Idle timeout after a partial entry
    press(4'h1);
    press(4'h2);
    repeat (T - 2) tick();
    check_outs("pre_timeout", 1'b0, 1'b0, 1'b0, 3'd2);
    tick();
    check_outs("timeout", 1'b0, 1'b1, 1'b0, 3'd0);

    // Key edge on the expiry cycle is accepted and restarts the timer
    press(4'h1);
    press(4'h2);
    repeat (T - 2) tick();
    key = 4'h3;
    tick();
    check_outs("edge_on_expiry", 1'b0, 1'b0, 1'b0, 3'd3);
    key = 4'h0;
    tick();
    repeat (T - 2) tick();
    check_outs("timer_restarted", 1'b0, 1'b0, 1'b0, 3'd3);
    tick();
    check_outs("timeout2", 1'b0, 1'b1, 1'b0, 3'd0);

    // Reset while locked mid-entry
    enter(16'h1234);
    enter(16'h1234);
    press(4'h1);
    check_outs("locked_mid_entry", 1'b1, 1'b0, 1'b0, 3'd1);
    #1 reset = 1'b1;
    #1;
    check_outs("reset_while_locked", 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
